// File: rtl/sw_pkg.sv
// Shared types and helpers for the packet-switch egress port stage.
package sw_pkg;

  localparam int unsigned MaxPorts = 16;
  localparam int unsigned MaxIdxW  = 4;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MaxIdxW-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned src_w(int unsigned num_ports);
    return (num_ports <= 2) ? 1 : $clog2(num_ports);
  endfunction

  // First set request found searching upward from last+1, wrapping at num_ports.
  function automatic rr_pick_t rr_pick(logic [MaxPorts-1:0] req, int unsigned last,
                                       int unsigned num_ports);
    rr_pick_t    res;
    int unsigned p;
    res = '0;
    for (int unsigned k = 1; k <= MaxPorts; k++) begin
      p = (last + k) % num_ports;
      if (k <= num_ports && !res.found && req[p]) begin
        res.found = 1'b1;
        res.idx   = p[MaxIdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sw_out_port_if.sv
// Ingress and egress flit handshake bundle of one switch egress port.
interface sw_out_port_if
  import sw_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8
);
  localparam int unsigned SrcW = src_w(NUM_PORTS);

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_sop;
  logic [NUM_PORTS-1:0]        in_eop;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_ready;
  logic                        out_valid;
  logic                        out_sop;
  logic                        out_eop;
  logic [SrcW-1:0]             out_src;
  logic [DATA_W-1:0]           out_data;
  logic                        out_ready;

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_src, out_data
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_src, out_data
  );
endinterface

// File: rtl/sw_sync_fifo.sv
// Synchronous FIFO for egress flits; head is read from the storage array, zero when empty.
module sw_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/sw_out_port.sv
// Egress port stage: packet-granular round-robin over ingress streams into a flit FIFO,
// with framing-error drop and saturating packet/drop statistics.
module sw_out_port
  import sw_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  sw_out_port_if.slave     bus,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err
);
  localparam int unsigned SrcW = src_w(NUM_PORTS);
  localparam int unsigned EntW = 2 + SrcW + DATA_W;
  localparam int unsigned NumW = $clog2(NUM_PORTS + 1);
  localparam int unsigned ExtW = CNT_W + 1;

  arb_state_e           state_q, state_d;
  logic [SrcW-1:0]      owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0]     pkt_q, pkt_d, drop_q, drop_d;
  logic                 err_q, err_d;
  rr_pick_t             pick;
  logic [SrcW-1:0]      sel;
  logic                 push, pkt_end, full, empty;
  logic [NUM_PORTS-1:0] ready, drop_vec;
  logic [NumW-1:0]      drop_num;
  logic [ExtW-1:0]      drop_sum;
  logic [DATA_W-1:0]    sel_data;
  logic [EntW-1:0]      rdata;

  assign pick     = rr_pick(MaxPorts'(bus.in_valid & bus.in_sop), 32'(last_q), NUM_PORTS);
  assign sel      = (state_q == StLocked) ? owner_q : SrcW'(pick.idx);
  assign sel_data = bus.in_data[sel*DATA_W +: DATA_W];

  always_comb begin
    ready    = '0;
    drop_vec = '0;
    push     = 1'b0;
    pkt_end  = 1'b0;
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle: begin
        // Headless flits are always accepted so a misframed source cannot wedge the port.
        drop_vec = bus.in_valid & ~bus.in_sop;
        ready    = drop_vec;
        if (pick.found) begin
          ready[sel] = ~full;
          push       = ~full;
          if (push) begin
            if (bus.in_eop[sel]) begin
              last_d  = sel;
              pkt_end = 1'b1;
            end else begin
              state_d = StLocked;
              owner_d = sel;
            end
          end
        end
      end
      StLocked: begin
        ready[sel] = ~full;
        push       = ~full & bus.in_valid[sel];
        if (push && bus.in_eop[sel]) begin
          state_d = StIdle;
          last_d  = sel;
          pkt_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_num = drop_num + NumW'(drop_vec[i]);
    drop_sum = {1'b0, drop_q} + ExtW'(drop_num);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    pkt_d    = (pkt_end && pkt_q != '1) ? pkt_q + CNT_W'(1) : pkt_q;
    err_d    = |drop_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= SrcW'(NUM_PORTS - 1);
      pkt_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  sw_sync_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({bus.in_sop[sel], bus.in_eop[sel], sel, sel_data}),
    .pop_i   (bus.out_ready),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready  = rst ? '0 : ready;
  assign bus.out_valid = ~empty;
  assign {bus.out_sop, bus.out_eop, bus.out_src, bus.out_data} = rdata;
  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
  assign err      = err_q;
endmodule

// File: tb/tb_sw_out_port.sv
// Directed bench for sw_out_port: arbitration, backpressure, framing drops and reset.
module tb_sw_out_port;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_cnt, drop_cnt;
  logic        err;
  int          total = 0;
  int          bad   = 0;
  logic [11:0] egress_q[$];

  sw_out_port_if #(.NUM_PORTS(4), .DATA_W(8)) bus ();

  sw_out_port #(
    .NUM_PORTS (4),
    .DATA_W    (8),
    .DEPTH     (16),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      egress_q.push_back({bus.out_sop, bus.out_eop, bus.out_src, bus.out_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [11:0] mk(bit s, bit e, logic [1:0] src, logic [7:0] d);
    return {s, e, src, d};
  endfunction

  task automatic set_flit(int p, bit s, bit e, logic [7:0] d);
    bus.in_valid[p]        = 1'b1;
    bus.in_sop[p]          = s;
    bus.in_eop[p]          = e;
    bus.in_data[p*8 +: 8]  = d;
  endtask

  task automatic clr_flit(int p);
    bus.in_valid[p] = 1'b0;
    bus.in_sop[p]   = 1'b0;
    bus.in_eop[p]   = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge once the flit has been accepted.
  task automatic send_flit(int p, bit s, bit e, logic [7:0] d, output bit ok);
    set_flit(p, s, e, d);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (bus.in_ready[p]) ok = 1'b1;
      @(negedge clk);
    end
    clr_flit(p);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!bus.out_valid) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_sop   = '0;
    bus.in_eop   = '0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    egress_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_sop   = '0;
    bus.in_eop   = '0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    set_flit(0, 1, 1, 8'h11);
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if ({bus.out_sop, bus.out_eop, bus.out_src, bus.out_data} !== 12'h000) begin
      bad++; $display("FAIL rst_out_fields: got %h want 000", {bus.out_sop, bus.out_eop, bus.out_src, bus.out_data});
    end
    total++; if (bus.in_ready !== 4'b0000) begin bad++; $display("FAIL rst_in_ready: got %b want 0000", bus.in_ready); end
    total++; if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 4'b0001) begin bad++; $display("FAIL rst_release_ready: got %b want 0001", bus.in_ready); end
    clr_flit(0);
  endtask

  task automatic test_single();
    bit ok1, ok2, okd;
    logic [11:0] exp[3];
    do_reset();
    bus.out_ready = 1'b1;
    set_flit(2, 1, 0, 8'hA0);
    #1;
    total++; if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus.in_ready); end
    @(posedge clk); #1;
    total++; if ({bus.out_valid, bus.out_sop, bus.out_src, bus.out_data} !== {1'b1, 1'b1, 2'd2, 8'hA0}) begin
      bad++; $display("FAIL single_latency: got v=%b sop=%b src=%0d data=%h want v=1 sop=1 src=2 data=a0",
                      bus.out_valid, bus.out_sop, bus.out_src, bus.out_data);
    end
    @(negedge clk);
    send_flit(2, 0, 0, 8'hA1, ok1);
    send_flit(2, 0, 1, 8'hA2, ok2);
    drain(okd);
    total++; if ({ok1, ok2, okd} !== 3'b111) begin bad++; $display("FAIL single_progress: got %b want 111", {ok1, ok2, okd}); end
    exp = '{mk(1, 0, 2, 8'hA0), mk(0, 0, 2, 8'hA1), mk(0, 1, 2, 8'hA2)};
    total++; if (egress_q.size() != 3) begin bad++; $display("FAIL single_count: got %0d want 3", egress_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (egress_q[i] !== exp[i]) begin bad++; $display("FAIL single_flit%0d: got %h want %h", i, egress_q[i], exp[i]); end
    end
    total++; if (pkt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL single_counters: got pkt=%0d drop=%0d want pkt=1 drop=0", pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_rr();
    bit [7:0] ok;
    bit okd;
    logic [11:0] exp[10];
    do_reset();
    bus.out_ready = 1'b1;
    fork
      begin send_flit(0, 1, 0, 8'h00, ok[0]); send_flit(0, 0, 1, 8'h01, ok[1]); end
      begin send_flit(1, 1, 0, 8'h10, ok[2]); send_flit(1, 0, 1, 8'h11, ok[3]); end
      begin send_flit(3, 1, 0, 8'h30, ok[4]); send_flit(3, 0, 1, 8'h31, ok[5]); end
    join
    fork
      begin send_flit(1, 1, 0, 8'h12, ok[6]); send_flit(1, 0, 1, 8'h13, ok[7]); end
      begin send_flit(0, 1, 0, 8'h02, okd); send_flit(0, 0, 1, 8'h03, okd); end
    join
    drain(okd);
    total++; if (ok !== 8'hFF || !okd) begin bad++; $display("FAIL rr_progress: got %b/%b want 11111111/1", ok, okd); end
    exp = '{mk(1, 0, 0, 8'h00), mk(0, 1, 0, 8'h01), mk(1, 0, 1, 8'h10), mk(0, 1, 1, 8'h11),
            mk(1, 0, 3, 8'h30), mk(0, 1, 3, 8'h31), mk(1, 0, 0, 8'h02), mk(0, 1, 0, 8'h03),
            mk(1, 0, 1, 8'h12), mk(0, 1, 1, 8'h13)};
    total++; if (egress_q.size() != 10) begin bad++; $display("FAIL rr_count: got %0d want 10", egress_q.size()); end
    else for (int i = 0; i < 10; i++) begin
      total++; if (egress_q[i] !== exp[i]) begin bad++; $display("FAIL rr_order%0d: got %h want %h", i, egress_q[i], exp[i]); end
    end
    total++; if (pkt_cnt !== 16'd5) begin bad++; $display("FAIL rr_pkt_cnt: got %0d want 5", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok, okd;
    int accepted = 0;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_flit(1, i == 0, 0, 8'(8'h40 + i), ok);
      if (ok) accepted++;
    end
    total++; if (accepted != 16) begin bad++; $display("FAIL bp_accepted: got %0d want 16", accepted); end
    set_flit(1, 0, 0, 8'h50);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({bus.in_ready[1], bus.out_valid, bus.out_sop, bus.out_eop, bus.out_src, bus.out_data} !==
                   {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 8'h40}) begin
        bad++; $display("FAIL bp_stall%0d: got rdy=%b v=%b sop=%b src=%0d data=%h want rdy=0 v=1 sop=1 src=1 data=40",
                        c, bus.in_ready[1], bus.out_valid, bus.out_sop, bus.out_src, bus.out_data);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send_flit(1, 0, 0, 8'h50, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_resume: got ready=0 want ready=1 after release"); end
    for (int i = 17; i < 20; i++) send_flit(1, 0, i == 19, 8'(8'h40 + i), ok);
    drain(okd);
    total++; if (!ok || !okd) begin bad++; $display("FAIL bp_tail: got %b%b want 11", ok, okd); end
    total++; if (egress_q.size() != 20) begin bad++; $display("FAIL bp_count: got %0d want 20", egress_q.size()); end
    else for (int i = 0; i < 20; i++) begin
      total++; if (egress_q[i] !== mk(i == 0, i == 19, 2'd1, 8'(8'h40 + i))) begin
        bad++; $display("FAIL bp_flit%0d: got %h want %h", i, egress_q[i], mk(i == 0, i == 19, 2'd1, 8'(8'h40 + i)));
      end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL bp_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_framing();
    bit okd;
    do_reset();
    bus.out_ready = 1'b1;
    set_flit(3, 0, 0, 8'hEE);
    set_flit(0, 1, 1, 8'h77);
    #1;
    total++; if (bus.in_ready !== 4'b1001) begin bad++; $display("FAIL frm_ready: got %b want 1001", bus.in_ready); end
    @(posedge clk); #1;
    total++; if (err !== 1'b1 || drop_cnt !== 16'd1) begin
      bad++; $display("FAIL frm_drop: got err=%b drop=%0d want err=1 drop=1", err, drop_cnt);
    end
    @(negedge clk);
    clr_flit(3);
    clr_flit(0);
    @(posedge clk); #1;
    total++; if (err !== 1'b0 || drop_cnt !== 16'd1) begin
      bad++; $display("FAIL frm_pulse: got err=%b drop=%0d want err=0 drop=1", err, drop_cnt);
    end
    drain(okd);
    total++; if (egress_q.size() != 1) begin bad++; $display("FAIL frm_count: got %0d want 1", egress_q.size()); end
    else begin
      total++; if (egress_q[0] !== mk(1, 1, 0, 8'h77)) begin bad++; $display("FAIL frm_flit: got %h want %h", egress_q[0], mk(1, 1, 0, 8'h77)); end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL frm_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_lock_hold();
    bit ok1, ok2, okd;
    logic [11:0] exp[3];
    do_reset();
    bus.out_ready = 1'b1;
    send_flit(0, 1, 0, 8'h01, ok1);
    set_flit(2, 1, 1, 8'h22);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.in_ready[2] !== 1'b0) begin bad++; $display("FAIL lock_hold%0d: got %b want 0", c, bus.in_ready[2]); end
      @(negedge clk);
    end
    send_flit(0, 0, 1, 8'h02, ok2);
    #1;
    total++; if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL lock_next: got %b want 0100", bus.in_ready); end
    @(negedge clk);
    clr_flit(2);
    drain(okd);
    total++; if ({ok1, ok2, okd} !== 3'b111) begin bad++; $display("FAIL lock_progress: got %b want 111", {ok1, ok2, okd}); end
    exp = '{mk(1, 0, 0, 8'h01), mk(0, 1, 0, 8'h02), mk(1, 1, 2, 8'h22)};
    total++; if (egress_q.size() != 3) begin bad++; $display("FAIL lock_count: got %0d want 3", egress_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (egress_q[i] !== exp[i]) begin bad++; $display("FAIL lock_flit%0d: got %h want %h", i, egress_q[i], exp[i]); end
    end
    total++; if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL lock_pkt_cnt: got %0d want 2", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok, okd;
    do_reset();
    bus.out_ready = 1'b0;
    send_flit(0, 1, 1, 8'h05, ok);
    send_flit(2, 1, 0, 8'hB0, ok);
    send_flit(2, 0, 0, 8'hB1, ok);
    #1;
    total++; if (pkt_cnt !== 16'd1 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_before: got pkt=%0d v=%b want pkt=1 v=1", pkt_cnt, bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || pkt_cnt !== 16'd0 || bus.in_ready !== 4'b0000) begin
      bad++; $display("FAIL rmid_async: got v=%b pkt=%0d rdy=%b want v=0 pkt=0 rdy=0000", bus.out_valid, pkt_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    egress_q.delete();
    set_flit(1, 1, 1, 8'hC1);
    set_flit(2, 1, 1, 8'hC2);
    #1;
    total++; if (bus.in_ready !== 4'b0010) begin bad++; $display("FAIL rmid_first: got %b want 0010", bus.in_ready); end
    @(negedge clk);
    clr_flit(1);
    #1;
    total++; if (bus.in_ready !== 4'b0100) begin bad++; $display("FAIL rmid_second: got %b want 0100", bus.in_ready); end
    @(negedge clk);
    clr_flit(2);
    bus.out_ready = 1'b1;
    drain(okd);
    total++; if (egress_q.size() != 2) begin bad++; $display("FAIL rmid_count: got %0d want 2", egress_q.size()); end
    else begin
      total++; if (egress_q[0] !== mk(1, 1, 1, 8'hC1) || egress_q[1] !== mk(1, 1, 2, 8'hC2)) begin
        bad++; $display("FAIL rmid_flits: got %h %h want %h %h", egress_q[0], egress_q[1], mk(1, 1, 1, 8'hC1), mk(1, 1, 2, 8'hC2));
      end
    end
    total++; if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL rmid_pkt_cnt: got %0d want 2", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_framing();
    test_lock_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
